// File: rtl/cdb_slot_sched.sv
// rtl/cdb_slot_sched.sv - CDB broadcast slot reservation scheduler for fixed-latency FUs
// Optional build macro CDB_SCHED_STATS_EN adds saturating grant/full-reject/squash counters.
module cdb_slot_sched #(
    parameter int N       = 2,
    parameter int NUM_REQ = 4,
    parameter int MAX_LAT = 8,
    parameter int BR_W    = 4,
    parameter int LW      = $clog2(MAX_LAT + 1)
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid,
    input  logic [NUM_REQ-1:0][LW-1:0]   req_lat,
    input  logic [NUM_REQ-1:0][BR_W-1:0] req_b_mask,
    input  logic [1:0]                   rem_br_task,
    input  logic [BR_W-1:0]              rem_b_id,
    output logic [NUM_REQ-1:0]           req_gnt,
    output logic [N-1:0]                 rsv_now,
    output logic [$clog2(N+1)-1:0]       rsv_count_now
`ifdef CDB_SCHED_STATS_EN
    ,
    output logic [31:0]                  stat_grants,
    output logic [31:0]                  stat_full_rejects,
    output logic [31:0]                  stat_squashed
`endif
);
    localparam int CW = $clog2(N + 1);
    localparam int HW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;
    localparam int RW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [1:0] BR_SQUASH = 2'd1;
    localparam logic [1:0] BR_CLEAR  = 2'd2;

    logic [MAX_LAT-1:0][N-1:0]           valid_q, valid_d;
    logic [MAX_LAT-1:0][N-1:0][BR_W-1:0] mask_q, mask_d;
    logic [HW-1:0]                       head_q, head_d;
    logic [RW-1:0]                       rr_ptr_q, rr_ptr_d;
    logic [N-1:0]                        rsv_now_q, rsv_now_d;
    logic [CW-1:0]                       rsv_count_q, rsv_count_d;

    int   tgt [NUM_REQ];
    int   added [MAX_LAT];
    int   idx, lat, occ;
    logic kill, placed;
    logic [BR_W-1:0] clr_bits;
`ifdef CDB_SCHED_STATS_EN
    logic [NUM_REQ-1:0] full_rej;
`endif

    // Round-robin scan; occupancy is the pre-squash table, and the current row
    // counts as empty for L=MAX_LAT because it is cleared before the write.
    always_comb begin
        req_gnt  = '0;
        rr_ptr_d = rr_ptr_q;
        idx = 0;
        lat = 0;
        occ = 0;
        kill = 1'b0;
        for (int r = 0; r < MAX_LAT; r++) added[r] = 0;
        for (int i = 0; i < NUM_REQ; i++) tgt[i] = 0;
`ifdef CDB_SCHED_STATS_EN
        full_rej = '0;
`endif
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = (int'(rr_ptr_q) + k) % NUM_REQ;
            lat = int'(req_lat[idx]);
            tgt[idx] = (int'(head_q) + lat) % MAX_LAT;
            occ = 0;
            if (lat != MAX_LAT) begin
                for (int e = 0; e < N; e++) occ = occ + int'(valid_q[tgt[idx]][e]);
            end
            kill = (rem_br_task == BR_SQUASH) && ((req_b_mask[idx] & rem_b_id) != '0);
            if (!reset && req_valid[idx] && lat >= 1 && lat <= MAX_LAT && !kill) begin
                if (occ + added[tgt[idx]] < N) begin
                    req_gnt[idx]       = 1'b1;
                    added[tgt[idx]]    = added[tgt[idx]] + 1;
                    rr_ptr_d           = RW'((idx + 1) % NUM_REQ);
                end else begin
`ifdef CDB_SCHED_STATS_EN
                    full_rej[idx] = 1'b1;
`endif
                end
            end
        end
    end

    always_comb begin
        valid_d  = valid_q;
        mask_d   = mask_q;
        placed   = 1'b0;
        clr_bits = (rem_br_task == BR_CLEAR) ? rem_b_id : '0;
        valid_d[head_q] = '0;
        for (int r = 0; r < MAX_LAT; r++) begin
            for (int e = 0; e < N; e++) begin
                if (rem_br_task == BR_SQUASH && (mask_q[r][e] & rem_b_id) != '0)
                    valid_d[r][e] = 1'b0;
                mask_d[r][e] = mask_q[r][e] & ~clr_bits;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            placed = 1'b0;
            if (req_gnt[i]) begin
                for (int e = 0; e < N; e++) begin
                    if (!placed && !valid_d[tgt[i]][e]) begin
                        valid_d[tgt[i]][e] = 1'b1;
                        mask_d[tgt[i]][e]  = req_b_mask[i] & ~clr_bits;
                        placed             = 1'b1;
                    end
                end
            end
        end
        head_d      = (head_q == HW'(MAX_LAT - 1)) ? '0 : head_q + HW'(1);
        rsv_now_d   = valid_d[head_d];
        rsv_count_d = '0;
        for (int e = 0; e < N; e++) rsv_count_d = rsv_count_d + CW'(rsv_now_d[e]);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            valid_q     <= '0;
            mask_q      <= '0;
            head_q      <= '0;
            rr_ptr_q    <= '0;
            rsv_now_q   <= '0;
            rsv_count_q <= '0;
        end else begin
            valid_q     <= valid_d;
            mask_q      <= mask_d;
            head_q      <= head_d;
            rr_ptr_q    <= rr_ptr_d;
            rsv_now_q   <= rsv_now_d;
            rsv_count_q <= rsv_count_d;
        end
    end

    assign rsv_now       = rsv_now_q;
    assign rsv_count_now = rsv_count_q;

`ifdef CDB_SCHED_STATS_EN
    logic [31:0] stat_grants_q, stat_grants_d;
    logic [31:0] stat_full_rejects_q, stat_full_rejects_d;
    logic [31:0] stat_squashed_q, stat_squashed_d;
    int          sq_cnt;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input int b);
        logic [32:0] s;
        s = {1'b0, a} + 33'(b);
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    // The current row is dropped on this edge regardless, so it is not counted as freed.
    always_comb begin
        sq_cnt = 0;
        for (int r = 0; r < MAX_LAT; r++) begin
            for (int e = 0; e < N; e++) begin
                if (rem_br_task == BR_SQUASH && r != int'(head_q) && valid_q[r][e] &&
                    (mask_q[r][e] & rem_b_id) != '0)
                    sq_cnt = sq_cnt + 1;
            end
        end
        stat_grants_d       = sat_add(stat_grants_q, $countones(req_gnt));
        stat_full_rejects_d = sat_add(stat_full_rejects_q, $countones(full_rej));
        stat_squashed_d     = sat_add(stat_squashed_q, sq_cnt);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stat_grants_q       <= '0;
            stat_full_rejects_q <= '0;
            stat_squashed_q     <= '0;
        end else begin
            stat_grants_q       <= stat_grants_d;
            stat_full_rejects_q <= stat_full_rejects_d;
            stat_squashed_q     <= stat_squashed_d;
        end
    end

    assign stat_grants       = stat_grants_q;
    assign stat_full_rejects = stat_full_rejects_q;
    assign stat_squashed     = stat_squashed_q;
`endif
endmodule

// File: doc/cdb_slot_sched.md
# cdb_slot_sched

CDB slot reservation scheduler sitting between the issue stage and the fixed-latency functional units. An issuing FU requests a broadcast slot L cycles ahead, and the block grants it only if fewer than N reservations already exist for that future cycle. Pre-reserved slots let pipelined FUs (multiplier, load hit path) write the CDB without being stalled by the CDB arbiter. Reservations carry a branch mask, so a squash frees the slots of killed instructions.

## Interface
- N, default `N: CDB broadcast width, i.e. maximum reservations per cycle.
- NUM_REQ, default 4: number of issue-side requesters.
- MAX_LAT, default 8: reservation window in cycles. Legal latencies are 1..MAX_LAT.
- LW, default $clog2(MAX_LAT+1): width of the latency field.
- clock  input  1: sole clock.
- reset  input  1: synchronous, active-high reset.
- req_valid  input  [NUM_REQ]: requester i asks for a slot this cycle.
- req_lat  input  [NUM_REQ][LW]: cycles until the FU's result is broadcast.
- req_b_mask  input  [NUM_REQ] BR_MASK: branch mask of the requesting instruction.
- rem_br_task  input  BR_TASK: NOTHING / SQUASH / CLEAR.
- rem_b_id  input  BR_MASK: one-hot branch being resolved.
- req_gnt  output  [NUM_REQ]: combinational grant, same cycle as the request.
- rsv_now  output  [N]: valid bits of the reservations held for the current cycle. Registered.
- rsv_count_now  output  [$clog2(N+1)]: popcount of rsv_now.

## Operation
- Table: MAX_LAT rows × N entries. Each entry is {valid, b_mask}.
- head pointer: row holding the current cycle.
- A grant with latency L writes row (head+L) mod MAX_LAT. This row is the current row L cycles later.
- Arbitration:
  - Requesters are scanned round-robin, starting at rr_ptr.
  - Requester i is granted iff all of the following hold:
    - req_valid[i];
    - 1 ≤ req_lat[i] ≤ MAX_LAT;
    - it is not being squashed this cycle: rem_br_task != SQUASH, or (req_b_mask[i] & rem_b_id) == 0;
    - the occupancy of the target row, plus grants already issued this cycle to that row, is less than N.
- Occupancy used for arbitration is the pre-squash registered state, which is conservative. Slots freed by a squash become usable the next cycle.
- A granted entry is written into the lowest-indexed free entry of its row. Entry order within a row carries no meaning.
- rr_ptr advances to (last granted index + 1) mod NUM_REQ. If no request is granted, rr_ptr is unchanged.
- Each cycle, the current row is exported on rsv_now, then cleared, and head increments mod MAX_LAT.
- SQUASH: every stored entry with (b_mask & rem_b_id) != 0 is invalidated.
- CLEAR: rem_b_id is cleared from every stored b_mask and from masks written this cycle.
- Same-cycle precedence: squash and clear are applied to newly granted entries as well as stored entries.
- Ungranted requesters must retry the next cycle. The block holds no request state.

## Timing
- Reset: all table entries invalid, head=0, rr_ptr=0, rsv_now=0, rsv_count_now=0.
- req_gnt is combinational from the inputs and the registered table, with no registered delay.
- A grant at cycle t with latency L appears in rsv_now during cycle t+L.
- L=MAX_LAT targets the current row's slot after wrap. This is legal because the current row is cleared on the same edge, before the write.
- Row full: any further requester targeting that row sees gnt=0, even if lower-priority requesters targeting other rows are granted.
- Reset asserted mid-operation discards all reservations on the next edge, and req_gnt=0 during reset.
- Illegal latency (0 or >MAX_LAT): never granted, and the table is unchanged.

## Configuration
- CDB_SCHED_STATS_EN defined:
  - Adds 32-bit saturating counters stat_grants, stat_full_rejects and stat_squashed. stat_squashed counts entries freed by SQUASH.
  - Exposes the counters as outputs, and resets them to 0.
- CDB_SCHED_STATS_EN undefined: the counters and their ports are absent, and behaviour is otherwise identical.

## Test plan
- Reset, then idle 10 cycles -> rsv_now=0 and req_gnt=0 every cycle; head wraps cleanly.
- N=2, NUM_REQ=4: requesters 0-3 all request L=3 at t=5 -> req_gnt=0011. At t=8, rsv_count_now=2. Same request at t=6 -> req_gnt=1100 (rr_ptr=2).
- Req0 L=2 with b_mask=0010 at t=4; SQUASH with rem_b_id=0010 at t=5 -> rsv_now=0 at t=6. A same-cycle request with mask 0010 during the squash -> gnt=0.
- Req0 L=4 with b_mask=0011; CLEAR with rem_b_id=0001 next cycle; SQUASH with rem_b_id=0001 two cycles later -> the entry survives and is visible at t+4.
- L=MAX_LAT grant at t, and L=0 and L=MAX_LAT+1 requests -> only the first is granted, and it appears at t+MAX_LAT.
- Fill rows, assert reset for one cycle -> every row is empty afterward, and a fresh grant of N requests to one row succeeds.
